// File: rtl/ct_vfmau_lza_lane_seq.sv
// Lane sequencer that time-shares one LZA across the SIMD lanes of a vector
// FMA normalisation request, active lanes lowest first, one per cycle.
module ct_vfmau_lza_lane_seq #(
  parameter int LANES = 4,
  parameter int OPW   = 24,
  parameter int RW    = 5
) (
  input  logic                   forever_cpuclk,
  input  logic                   cpurst_b,
  input  logic                   flush,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic [LANES*OPW-1:0]   req_summand,
  input  logic [LANES*OPW-1:0]   req_addend,
  input  logic [LANES-1:0]       req_sub,
  input  logic [LANES-1:0]       req_mask,
  output logic [OPW-1:0]         lza_summand,
  output logic [OPW-1:0]         lza_addend,
  output logic                   lza_sub_vld,
  input  logic [RW-1:0]          lza_result,
  input  logic                   lza_result_zero,
  output logic                   rsp_vld,
  input  logic                   rsp_rdy,
  output logic [LANES*RW-1:0]    rsp_lza,
  output logic [LANES-1:0]       rsp_zero,
  output logic [LANES-1:0]       rsp_mask,
  output logic                   busy
);

  localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [LANES*OPW-1:0] summand_reg, addend_reg;
  logic [LANES-1:0]     sub_reg, mask_reg, zero_reg;
  logic [LANES*RW-1:0]  lza_reg;
  logic [PW-1:0]        ptr_reg, ptr_next, first_ptr, after_ptr;
  logic                 has_after, accept;
  logic [OPW-1:0]       summand_lane [LANES];
  logic [OPW-1:0]       addend_lane  [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign summand_lane[gi] = summand_reg[gi*OPW +: OPW];
      assign addend_lane[gi]  = addend_reg[gi*OPW +: OPW];
    end
  endgenerate

  // Lowest set bit of the incoming mask: the first lane to evaluate.
  always_comb begin
    first_ptr = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (req_mask[i]) first_ptr = PW'(i);
    end
  end

  // Next active lane strictly above the current one; inactive lanes are skipped.
  always_comb begin
    after_ptr = '0;
    has_after = 1'b0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (mask_reg[i] && (i > int'(ptr_reg))) begin
        after_ptr = PW'(i);
        has_after = 1'b1;
      end
    end
  end

  assign req_rdy = !flush && ((state_reg == IDLE) || ((state_reg == DONE) && rsp_rdy));
  assign accept  = req_vld && req_rdy;

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    if (flush) begin
      state_next = IDLE;
    end else if (accept) begin
      state_next = (req_mask != '0) ? RUN : DONE;
      ptr_next   = first_ptr;
    end else begin
      case (state_reg)
        RUN: begin
          if (has_after) ptr_next = after_ptr;
          else           state_next = DONE;
        end
        DONE: begin
          if (rsp_rdy) state_next = IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg   <= IDLE;
      ptr_reg     <= '0;
      summand_reg <= '0;
      addend_reg  <= '0;
      sub_reg     <= '0;
      mask_reg    <= '0;
      lza_reg     <= '0;
      zero_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      if (accept) begin
        summand_reg <= req_summand;
        addend_reg  <= req_addend;
        sub_reg     <= req_sub;
        mask_reg    <= req_mask;
        lza_reg     <= '0;
        zero_reg    <= '0;
      end else if ((state_reg == RUN) && !flush) begin
        lza_reg[ptr_reg*RW +: RW] <= lza_result;
        zero_reg[ptr_reg]         <= lza_result_zero;
      end
    end
  end

  // LZA operands come only from captured state, never straight from req_*.
  always_comb begin
    lza_summand = '0;
    lza_addend  = '0;
    lza_sub_vld = 1'b0;
    if (state_reg == RUN) begin
      lza_summand = summand_lane[ptr_reg];
      lza_addend  = addend_lane[ptr_reg];
      lza_sub_vld = sub_reg[ptr_reg];
    end
  end

  assign rsp_vld  = (state_reg == DONE);
  assign rsp_lza  = lza_reg;
  assign rsp_zero = zero_reg;
  assign rsp_mask = mask_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_ct_vfmau_lza_lane_seq.sv
// Bench for ct_vfmau_lza_lane_seq: transaction-level model of expected
// responses and lane presentation, plus hand-computed directed vectors.
module tb_ct_vfmau_lza_lane_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [95:0] req_summand = '0;
  logic [95:0] req_addend = '0;
  logic [3:0]  req_sub = '0;
  logic [3:0]  req_mask = '0;
  logic [23:0] lza_summand, lza_addend;
  logic        lza_sub_vld;
  logic [4:0]  lza_result;
  logic        lza_result_zero;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b1;
  logic [19:0] rsp_lza;
  logic [3:0]  rsp_zero, rsp_mask;
  logic        busy;
  logic        stub_mode = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  typedef struct {
    logic [95:0] s;
    logic [95:0] a;
    logic [3:0]  sub;
    logic [3:0]  mask;
    logic [19:0] lza;
    logic [3:0]  zero;
    int          acc;
    int          due;
  } txn_t;

  txn_t q[$];

  ct_vfmau_lza_lane_seq #(.LANES(4), .OPW(24), .RW(5)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .flush          (flush),
    .req_vld        (req_vld),
    .req_rdy        (req_rdy),
    .req_summand    (req_summand),
    .req_addend     (req_addend),
    .req_sub        (req_sub),
    .req_mask       (req_mask),
    .lza_summand    (lza_summand),
    .lza_addend     (lza_addend),
    .lza_sub_vld    (lza_sub_vld),
    .lza_result     (lza_result),
    .lza_result_zero(lza_result_zero),
    .rsp_vld        (rsp_vld),
    .rsp_rdy        (rsp_rdy),
    .rsp_lza        (rsp_lza),
    .rsp_zero       (rsp_zero),
    .rsp_mask       (rsp_mask),
    .busy           (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Exact leading-zero count of the 24-bit sum/difference, or a stub that
  // returns 3 + summand[4:0] so lane identity shows up in the result.
  function automatic logic [5:0] lza_ref(logic [23:0] s, logic [23:0] a, logic sub, logic stub);
    logic [23:0] r;
    int n;
    if (stub) return {1'b0, 5'd3 + s[4:0]};
    r = sub ? (s - a) : (s + a);
    n = 0;
    for (int b = 23; b >= 0; b--) begin
      if (r[b]) break;
      n++;
    end
    return {(r == 24'd0), 5'(n)};
  endfunction

  function automatic int nth_set(logic [3:0] m, int k);
    int c;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        if (c == k) return i;
        c++;
      end
    end
    return 0;
  endfunction

  function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endfunction

  always_comb {lza_result_zero, lza_result} = lza_ref(lza_summand, lza_addend, lza_sub_vld, stub_mode);

  // Per-cycle compare against the transaction model.
  always @(negedge clk) begin : cmp
    logic        e_vld, e_rdy, esub;
    logic [23:0] es, ea;
    logic [5:0]  r6;
    int          ln;
    txn_t        t;
    if (chk_en) begin
      e_vld = 1'b0;
      if (q.size() > 0) e_vld = (cyc >= q[0].due);
      e_rdy = !flush && ((q.size() == 0) || (e_vld && rsp_rdy));
      chk("req_rdy", req_rdy, e_rdy);
      chk("busy", busy, q.size() > 0);
      chk("rsp_vld", rsp_vld, e_vld);
      es = '0; ea = '0; esub = 1'b0;
      if (q.size() > 0) begin
        if ((cyc > q[0].acc) && (cyc < q[0].due)) begin
          ln   = nth_set(q[0].mask, cyc - q[0].acc - 1);
          es   = q[0].s[ln*24 +: 24];
          ea   = q[0].a[ln*24 +: 24];
          esub = q[0].sub[ln];
        end
      end
      chk("lza_summand", lza_summand, es);
      chk("lza_addend", lza_addend, ea);
      chk("lza_sub_vld", lza_sub_vld, esub);
      if (e_vld) begin
        chk("rsp_lza", rsp_lza, q[0].lza);
        chk("rsp_zero", rsp_zero, q[0].zero);
        chk("rsp_mask", rsp_mask, q[0].mask);
        if (rsp_rdy) begin
          $display("rsp cycle=%0d mask=%b lza=%h zero=%b", cyc, rsp_mask, rsp_lza, rsp_zero);
          void'(q.pop_front());
        end
      end
      if (req_vld && e_rdy) begin
        t.s = req_summand; t.a = req_addend; t.sub = req_sub; t.mask = req_mask;
        t.lza = '0; t.zero = '0;
        for (int i = 0; i < 4; i++) begin
          if (req_mask[i]) begin
            r6 = lza_ref(req_summand[i*24 +: 24], req_addend[i*24 +: 24], req_sub[i], stub_mode);
            t.lza[i*5 +: 5] = r6[4:0];
            t.zero[i] = r6[5];
          end
        end
        t.acc = cyc;
        t.due = cyc + 1 + $countones(req_mask);
        q.push_back(t);
        $display("req cycle=%0d mask=%b sub=%b", cyc, req_mask, req_sub);
      end
      if (flush) q.delete();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] m, input logic [3:0] sub, input logic [95:0] s, input logic [95:0] a);
    req_vld = 1'b1; req_mask = m; req_sub = sub; req_summand = s; req_addend = a;
  endtask

  task automatic await_accept(output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!req_rdy && t < 64) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    chk("accept_timeout", req_rdy, 1'b1);
    step();
    req_vld = 1'b0;
  endtask

  task automatic await_rsp(output int at);
    int t;
    t = 0;
    @(negedge clk);
    while (!rsp_vld && t < 64) begin
      @(negedge clk);
      t++;
    end
    at = cyc;
    chk("rsp_timeout", rsp_vld, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int a1, a2, r1, r2;
    // Reset values
    step(); step();
    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_req_rdy", req_rdy, 1'b1);
    chk("rst_lza_summand", lza_summand, 24'd0);
    chk("rst_lza_sub", lza_sub_vld, 1'b0);
    chk("rst_rsp_lza", rsp_lza, 20'd0);
    chk("rst_rsp_mask", rsp_mask, 4'd0);
    step();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: single lane, real LZA
    drive(4'b0001, 4'b0000, {72'h0, 24'h800000}, '0);
    await_accept(a1); await_rsp(r1);
    chk("t1_latency", r1 - a1, 2);
    chk("t1_lza", rsp_lza, 20'h00000);
    chk("t1_zero", rsp_zero, 4'b0000);
    chk("t1_mask", rsp_mask, 4'b0001);
    step();

    // 2: all-zero lane, other lanes carry data but are masked off
    drive(4'b0100, 4'b0000, {24'h123456, 24'h000000, 24'habcdef, 24'hfedcba}, '0);
    await_accept(a1); await_rsp(r1);
    chk("t2_latency", r1 - a1, 2);
    chk("t2_lza", rsp_lza, 20'h06000);
    chk("t2_zero", rsp_zero, 4'b0100);
    step();

    // 3: sparse mask with stub LZA
    stub_mode = 1'b1;
    drive(4'b1010, 4'b0000, {24'd3, 24'd2, 24'd1, 24'd0}, '0);
    await_accept(a1);
    @(negedge clk);
    chk("t3_first_lane", lza_summand, 24'd1);
    chk("t3_first_cycle", cyc - a1, 1);
    @(negedge clk);
    chk("t3_second_lane", lza_summand, 24'd3);
    @(negedge clk);
    chk("t3_vld", rsp_vld, 1'b1);
    chk("t3_latency", cyc - a1, 3);
    chk("t3_lza", rsp_lza, 20'h30080);
    chk("t3_zero", rsp_zero, 4'b0000);
    step();
    stub_mode = 1'b0;

    // 4: empty mask
    drive(4'b0000, 4'b1111, {24'h111111, 24'h222222, 24'h333333, 24'h444444}, '0);
    await_accept(a1); await_rsp(r1);
    chk("t4_latency", r1 - a1, 1);
    chk("t4_lza", rsp_lza, 20'h00000);
    chk("t4_mask", rsp_mask, 4'b0000);
    step();

    // 5: back-to-back full masks, then a stalled response
    drive(4'b1111, 4'b1001, {24'h000001, 24'h00ff00, 24'h400000, 24'h0000f0},
          {24'h000001, 24'h000100, 24'h000000, 24'h000010});
    await_accept(a1);
    drive(4'b1111, 4'b0000, {4{24'h000800}}, '0);
    await_rsp(r1);
    chk("t5a_latency", r1 - a1, 5);
    chk("t5a_lza", rsp_lza, 20'hC1C30);
    chk("t5a_zero", rsp_zero, 4'b1000);
    chk("t5_b2b_rdy", req_rdy, 1'b1);
    step();
    req_vld = 1'b0;
    await_rsp(r2);
    chk("t5_rsp_spacing", r2 - r1, 5);
    chk("t5b_lza", rsp_lza, 20'h6318C);
    step();
    rsp_rdy = 1'b0;
    drive(4'b0011, 4'b0000, {24'h0, 24'h0, 24'h020000, 24'h000001}, '0);
    await_accept(a1); await_rsp(r1);
    chk("t5c_latency", r1 - a1, 3);
    step();
    drive(4'b1111, 4'b1111, {24'h000005, 24'h000077, 24'h000123, 24'habcdef},
          {24'h000005, 24'h000077, 24'h000123, 24'habcdef});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_rdy", req_rdy, 1'b0);
      chk("t5_stall_vld", rsp_vld, 1'b1);
      chk("t5_stall_lza", rsp_lza, 20'h000D7);
      chk("t5_stall_mask", rsp_mask, 4'b0011);
    end
    step();
    rsp_rdy = 1'b1;
    await_accept(a2); await_rsp(r2);
    chk("t5d_latency", r2 - a2, 5);
    chk("t5d_lza", rsp_lza, 20'hC6318);
    chk("t5d_zero", rsp_zero, 4'b1111);
    step();

    // 6: flush in the second RUN cycle with a request pending
    drive(4'b1111, 4'b1001, {24'h000001, 24'h00ff00, 24'h400000, 24'h0000f0},
          {24'h000001, 24'h000100, 24'h000000, 24'h000010});
    await_accept(a1);
    step();
    flush = 1'b1;
    drive(4'b0110, 4'b0100, {24'h0, 24'h000004, 24'h000100, 24'h0}, {24'h0, 24'h000003, 24'h0, 24'h0});
    @(negedge clk);
    chk("t6_flush_rdy", req_rdy, 1'b0);
    chk("t6_flush_lane", lza_summand, 24'h400000);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("t6_idle_busy", busy, 1'b0);
    chk("t6_idle_vld", rsp_vld, 1'b0);
    chk("t6_idle_rdy", req_rdy, 1'b1);
    a2 = cyc;
    chk("t6_accept_cycle", a2 - a1, 3);
    step();
    req_vld = 1'b0;
    await_rsp(r2);
    chk("t6_latency", r2 - a2, 3);
    chk("t6_lza", rsp_lza, 20'h05DE0);
    step();

    // 7: reset mid-RUN
    drive(4'b1111, 4'b0000, {4{24'h00000f}}, '0);
    await_accept(a1);
    chk_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t7_busy", busy, 1'b0);
    chk("t7_vld", rsp_vld, 1'b0);
    chk("t7_lza_summand", lza_summand, 24'd0);
    chk("t7_rsp_mask", rsp_mask, 4'd0);
    chk("t7_rsp_lza", rsp_lza, 20'd0);
    q.delete();
    step();
    rst_n = 1'b1;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
